// File: rtl/npu_bank_arbiter.sv
// npu_bank_arbiter: host / tile-processor arbitration for NUM_BANKS
// single-port NPU SRAM banks, with per-bank read-return routing.
module npu_bank_arbiter #(
  parameter int NUM_BANKS  = 3,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1,
  parameter int MAX_HBURST = 4,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        lock,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [BANK_W-1:0]           host_bank,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_gnt,
  output logic                        host_err,
  output logic                        host_rvalid,
  output logic [DATA_W-1:0]           host_rdata,
  input  logic [NUM_BANKS-1:0]        tp_req,
  input  logic [NUM_BANKS-1:0]        tp_we,
  input  logic [NUM_BANKS*ADDR_W-1:0] tp_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] tp_wdata,
  output logic [NUM_BANKS-1:0]        tp_gnt,
  output logic [NUM_BANKS-1:0]        tp_rvalid,
  output logic [NUM_BANKS*DATA_W-1:0] tp_rdata,
  output logic [NUM_BANKS-1:0]        bank_ce,
  output logic [NUM_BANKS-1:0]        bank_we,
  output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS*DATA_W-1:0] bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata
);

  localparam int CNT_W = $clog2(MAX_HBURST + 1);
  localparam logic [BANK_W:0] NB = (BANK_W+1)'(NUM_BANKS);

  logic                 host_ok;
  logic                 bad_bank;
  logic [NUM_BANKS-1:0] host_win;
  logic [NUM_BANKS-1:0] tp_win;
  logic [NUM_BANKS-1:0] host_rv;

  assign host_ok  = host_req & ~lock;
  assign bad_bank = host_ok & ({1'b0, host_bank} >= NB);

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    localparam logic [BANK_W-1:0] KB = BANK_W'(k);

    logic [CNT_W-1:0]  hcnt;
    logic              hit;
    logic              sat;
    logic              rd_issue;
    logic              ce_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [RD_LAT:0]   rv;
    logic [RD_LAT:0]   rh;

    assign hit         = host_ok & (host_bank == KB);
    assign sat         = tp_req[k] & (hcnt == CNT_W'(MAX_HBURST));
    assign host_win[k] = hit & ~sat;
    assign tp_win[k]   = tp_req[k] & ~host_win[k];
    assign rd_issue    = (host_win[k] & ~host_we)
                       | (tp_win[k] & ~tp_we[k]);

    // A host win under contention implies hcnt < MAX_HBURST.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt <= '0;
      end else if (!tp_req[k] || tp_win[k]) begin
        hcnt <= '0;
      end else if (host_win[k]) begin
        hcnt <= hcnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ce_q    <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
      end else begin
        ce_q <= host_win[k] | tp_win[k];
        we_q <= host_win[k] ? host_we : (tp_win[k] & tp_we[k]);
        if (host_win[k]) begin
          addr_q  <= host_addr;
          wdata_q <= host_wdata;
        end else if (tp_win[k]) begin
          addr_q  <= tp_addr[k*ADDR_W +: ADDR_W];
          wdata_q <= tp_wdata[k*DATA_W +: DATA_W];
        end
      end
    end

    // rv tags an issued read, rh marks it as owned by the host.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv <= '0;
        rh <= '0;
      end else begin
        rv <= {rv[RD_LAT-1:0], rd_issue};
        rh <= {rh[RD_LAT-1:0], host_win[k]};
      end
    end

    assign bank_ce[k] = ce_q;
    assign bank_we[k] = we_q;
    assign bank_addr[k*ADDR_W +: ADDR_W]  = addr_q;
    assign bank_wdata[k*DATA_W +: DATA_W] = wdata_q;

    assign host_rv[k]   = rv[RD_LAT] & rh[RD_LAT];
    assign tp_rvalid[k] = rv[RD_LAT] & ~rh[RD_LAT];
    assign tp_rdata[k*DATA_W +: DATA_W] =
      tp_rvalid[k] ? bank_rdata[k*DATA_W +: DATA_W] : '0;
  end

  // At most one host read returns per cycle, so OR-ing is a clean mux.
  always_comb begin
    host_rdata = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (host_rv[k]) begin
        host_rdata = host_rdata | bank_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign host_rvalid = |host_rv;
  assign host_gnt    = rst_n & ((|host_win) | bad_bank);
  assign host_err    = rst_n & bad_bank;
  assign tp_gnt      = rst_n ? tp_win : '0;

endmodule

// File: tb/tb_npu_bank_arbiter.sv
// tb_npu_bank_arbiter: vector table plus read-return scoreboard
// against a behavioural SRAM model with one cycle of read latency.
module tb_npu_bank_arbiter;

  localparam int NB = 3;
  localparam int DW = 8;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic lock;
  logic host_req;
  logic host_we;
  logic [1:0] host_bank;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic host_gnt;
  logic host_err;
  logic host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [NB-1:0] tp_req;
  logic [NB-1:0] tp_we;
  logic [NB*AW-1:0] tp_addr;
  logic [NB*DW-1:0] tp_wdata;
  logic [NB-1:0] tp_gnt;
  logic [NB-1:0] tp_rvalid;
  logic [NB*DW-1:0] tp_rdata;
  logic [NB-1:0] bank_ce;
  logic [NB-1:0] bank_we;
  logic [NB*AW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_wdata;
  logic [NB*DW-1:0] bank_rdata;

  npu_bank_arbiter #(
    .NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW),
    .RD_LAT(1), .MAX_HBURST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lock(lock),
    .host_req(host_req), .host_we(host_we),
    .host_bank(host_bank), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_err(host_err), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .tp_req(tp_req),
    .tp_we(tp_we), .tp_addr(tp_addr),
    .tp_wdata(tp_wdata), .tp_gnt(tp_gnt),
    .tp_rvalid(tp_rvalid), .tp_rdata(tp_rdata),
    .bank_ce(bank_ce), .bank_we(bank_we),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model
  logic [DW-1:0] mem [NB][1<<AW];
  logic [NB*DW-1:0] rdq;
  assign bank_rdata = rdq;

  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (bank_ce[k]) begin
        if (bank_we[k])
          mem[k][bank_addr[k*AW +: AW]] <= bank_wdata[k*DW +: DW];
        else
          rdq[k*DW +: DW] <= mem[k][bank_addr[k*AW +: AW]];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               n, a, e, cyc);
    end
  endtask

  typedef struct {
    bit host;
    int bank;
    logic [DW-1:0] data;
    int due;
  } sb_t;

  sb_t sb[$];
  logic [DW-1:0] rmem [NB][1<<AW];

  // Read-return monitor
  always @(negedge clk) begin
    sb_t e;
    logic [NB-1:0] seen_tp;
    bit seen_h;
    seen_tp = '0;
    seen_h = 1'b0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.host) begin
        chk("host_rvalid", 32'(host_rvalid), 32'd1);
        chk("host_rdata", 32'(host_rdata), 32'(e.data));
        seen_h = 1'b1;
      end else begin
        chk($sformatf("tp_rvalid%0d", e.bank),
            32'(tp_rvalid[e.bank]), 32'd1);
        chk($sformatf("tp_rdata%0d", e.bank),
            32'(tp_rdata[e.bank*DW +: DW]), 32'(e.data));
        seen_tp[e.bank] = 1'b1;
      end
    end
    if (!seen_h) begin
      chk("host_rvalid idle", 32'(host_rvalid), 32'd0);
      chk("host_rdata idle", 32'(host_rdata), 32'd0);
    end
    for (int k = 0; k < NB; k++) begin
      if (!seen_tp[k]) begin
        chk($sformatf("tp_rvalid%0d idle", k),
            32'(tp_rvalid[k]), 32'd0);
        chk($sformatf("tp_rdata%0d idle", k),
            32'(tp_rdata[k*DW +: DW]), 32'd0);
      end
    end
  end

  typedef struct {
    logic lk, hr, hw;
    logic [1:0] hb;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic [NB-1:0] tr, tw;
    logic eg, ee;
    logic [NB-1:0] et, ec, ew;
  } vec_t;

  function automatic vec_t mk(
    input logic lk, hr, hw, input logic [1:0] hb,
    input logic [AW-1:0] ha, input logic [DW-1:0] hd,
    input logic [NB-1:0] tr, tw, input logic eg, ee,
    input logic [NB-1:0] et, ec, ew);
    vec_t v;
    v.lk = lk; v.hr = hr; v.hw = hw; v.hb = hb;
    v.ha = ha; v.hd = hd; v.tr = tr; v.tw = tw;
    v.eg = eg; v.ee = ee; v.et = et; v.ec = ec; v.ew = ew;
    return v;
  endfunction

  // Called just after a rising edge; spans exactly one cycle.
  task automatic drive_row(input vec_t v, input int idx);
    bit hwon;
    logic [AW-1:0] ea;
    lock = v.lk; host_req = v.hr; host_we = v.hw;
    host_bank = v.hb; host_addr = v.ha; host_wdata = v.hd;
    tp_req = v.tr; tp_we = v.tw;
    @(negedge clk);
    chk($sformatf("r%0d host_gnt", idx), 32'(host_gnt), 32'(v.eg));
    chk($sformatf("r%0d host_err", idx), 32'(host_err), 32'(v.ee));
    chk($sformatf("r%0d tp_gnt", idx), 32'(tp_gnt), 32'(v.et));
    if (v.eg && !v.ee) begin
      if (v.hw) rmem[int'(v.hb)][v.ha] = v.hd;
      else sb.push_back('{1'b1, int'(v.hb),
                          rmem[int'(v.hb)][v.ha], cyc + 2});
    end
    for (int k = 0; k < NB; k++) begin
      if (v.et[k]) begin
        if (v.tw[k])
          rmem[k][tp_addr[k*AW +: AW]] = tp_wdata[k*DW +: DW];
        else
          sb.push_back('{1'b0, k, rmem[k][tp_addr[k*AW +: AW]],
                         cyc + 2});
      end
    end
    @(posedge clk); #1;
    chk($sformatf("r%0d bank_ce", idx), 32'(bank_ce), 32'(v.ec));
    chk($sformatf("r%0d bank_we", idx), 32'(bank_we), 32'(v.ew));
    for (int k = 0; k < NB; k++) begin
      if (v.ec[k]) begin
        hwon = v.eg && !v.ee && (int'(v.hb) == k);
        ea = hwon ? v.ha : tp_addr[k*AW +: AW];
        chk($sformatf("r%0d bank_addr%0d", idx, k),
            32'(bank_addr[k*AW +: AW]), 32'(ea));
        if (v.ew[k])
          chk($sformatf("r%0d bank_wdata%0d", idx, k),
              32'(bank_wdata[k*DW +: DW]),
              32'(hwon ? v.hd : tp_wdata[k*DW +: DW]));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    bit t;
    tp_addr  = {10'h030, 10'h020, 10'h010};
    tp_wdata = {8'h32, 8'h31, 8'h30};

    // Reset with every requester active
    rst_n = 1'b0; lock = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_bank = 2'd0;
    host_addr = 10'h100; host_wdata = 8'h77;
    tp_req = 3'b111; tp_we = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst host_gnt", 32'(host_gnt), 32'd0);
    chk("rst host_err", 32'(host_err), 32'd0);
    chk("rst tp_gnt", 32'(tp_gnt), 32'd0);
    chk("rst bank_ce", 32'(bank_ce), 32'd0);
    chk("rst bank_we", 32'(bank_we), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel host_gnt", 32'(host_gnt), 32'd1);
    chk("rel tp_gnt", 32'(tp_gnt), 32'b110);
    rmem[0][10'h100] = 8'h77;
    rmem[1][10'h020] = 8'h31;
    rmem[2][10'h030] = 8'h32;
    @(posedge clk); #1;
    chk("rel bank_ce", 32'(bank_ce), 32'b111);
    chk("rel bank_we", 32'(bank_we), 32'b111);
    host_req = 1'b0; tp_req = 3'b000;

    tbl.push_back(mk(0,0,0,2'd0,10'h000,8'h00,3'b000,3'b000,
                     0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(0,1,1,2'd1,10'h155,8'hA5,3'b000,3'b000,
                     1,0,3'b000,3'b010,3'b010));
    tbl.push_back(mk(0,1,0,2'd1,10'h155,8'h00,3'b000,3'b000,
                     1,0,3'b000,3'b010,3'b000));
    tbl.push_back(mk(0,0,0,2'd0,10'h000,8'h00,3'b000,3'b000,
                     0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(0,0,0,2'd0,10'h000,8'h00,3'b111,3'b111,
                     0,0,3'b111,3'b111,3'b111));
    tbl.push_back(mk(0,0,0,2'd0,10'h000,8'h00,3'b111,3'b000,
                     0,0,3'b111,3'b111,3'b000));
    tbl.push_back(mk(0,1,0,2'd3,10'h0AA,8'h00,3'b000,3'b000,
                     1,1,3'b000,3'b000,3'b000));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1,1,0,2'd2,10'h011,8'h00,3'b100,3'b000,
                       0,0,3'b100,3'b100,3'b000));
    tbl.push_back(mk(1,1,1,2'd0,10'h001,8'h11,3'b000,3'b000,
                     0,0,3'b000,3'b000,3'b000));
    // Bank 0 contention: four host wins, then one compute win
    for (int i = 0; i < 10; i++) begin
      t = (i % 5 == 4);
      tbl.push_back(mk(0,1,1,2'd0,10'h200,8'h5A,3'b001,3'b001,
                       !t,0,t ? 3'b001 : 3'b000,3'b001,3'b001));
    end
    tbl.push_back(mk(0,1,1,2'd2,10'h3FF,8'hC3,3'b001,3'b001,
                     1,0,3'b001,3'b101,3'b101));
    tbl.push_back(mk(0,1,0,2'd2,10'h3FF,8'h00,3'b000,3'b000,
                     1,0,3'b000,3'b100,3'b000));
    tbl.push_back(mk(0,1,0,2'd0,10'h200,8'h00,3'b001,3'b000,
                     1,0,3'b000,3'b001,3'b000));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0,0,0,2'd0,10'h000,8'h00,3'b000,3'b000,
                       0,0,3'b000,3'b000,3'b000));

    foreach (tbl[i]) drive_row(tbl[i], i);

    // Concurrent compute reads killed by a reset pulse
    host_req = 1'b0; lock = 1'b0;
    tp_req = 3'b111; tp_we = 3'b000;
    @(negedge clk);
    chk("abort tp_gnt", 32'(tp_gnt), 32'b111);
    @(posedge clk); #1;
    tp_req = 3'b000;
    chk("abort bank_ce", 32'(bank_ce), 32'b111);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort rst bank_ce", 32'(bank_ce), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort tp_rvalid", 32'(tp_rvalid), 32'd0);
      chk("abort host_rvalid", 32'(host_rvalid), 32'd0);
    end

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
